// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction format, opcodes and the fetch
// sequencer state encoding used by the sequencer, Controller and bench.
package cpu_pkg;

  localparam int INSTR_W  = 16;
  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LDA = 3'b000,
    OP_STA = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_JMP = 3'b100,
    OP_JEZ = 3'b101,
    OP_LDI = 3'b110,
    OP_HLT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pc_counter.sv
// Program counter with start reload, jump load and wrapping increment.
module pc_counter #(
  parameter int                 ADDR_W     = 13,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              incr,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // PC register; increment wraps naturally at 2^ADDR_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= START_ADDR;
    end else if (load_start) begin
      pc <= START_ADDR;
    end else if (load_jump) begin
      pc <= jump_addr;
    end else if (incr) begin
      pc <= pc + PC_ONE;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: owns the PC, fetches instructions over a
// req/ack handshake, presents opcode/operand and stops on HLT.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | after reset; waits for start
//   ST_FETCH | imem_req high at imem_addr=pc until imem_ack
//   ST_EXEC  | one-cycle exec_valid strobe; pc updated at its end
//   ST_HALT  | HLT executed; halted=1, waits for start
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W     = 13,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   operand,
  output logic                exec_valid,
  input  logic                pc_src,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted
);

  seq_state_e state_q;
  seq_state_e state_d;

  logic load_start;
  logic load_jump;
  logic incr;
  logic is_hlt;

  assign is_hlt = (opcode == OP_HLT);

  // State register; async reset drops imem_req immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)    state_d = ST_FETCH;
      ST_FETCH: if (imem_ack) state_d = ST_EXEC;
      ST_EXEC:  state_d = is_hlt ? ST_HALT : ST_FETCH;
      ST_HALT:  if (start)    state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore outputs and PC control, decoded from registered state only
  always_comb begin
    imem_req   = 1'b0;
    exec_valid = 1'b0;
    halted     = 1'b0;
    load_start = 1'b0;
    load_jump  = 1'b0;
    incr       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_start = start;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
      end
      ST_EXEC: begin
        exec_valid = 1'b1;
        // HLT ignores pc_src and always advances
        load_jump  = pc_src && !is_hlt;
        incr       = !(pc_src && !is_hlt);
      end
      ST_HALT: begin
        halted     = 1'b1;
        load_start = start;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // Instruction latch; fields hold until the next accepted fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode  <= '0;
      operand <= '0;
    end else if (state_q == ST_FETCH && imem_ack) begin
      opcode  <= imem_rdata[INSTR_W-1 -: OPCODE_W];
      operand <= imem_rdata[ADDR_W-1:0];
    end
  end

  pc_counter #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_pc_counter (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_jump  (load_jump),
    .jump_addr  (operand),
    .incr       (incr),
    .pc         (pc)
  );

  assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized instruction streams against a transaction-level PC model.
module tb_fetch_sequencer;

  localparam int ADDR_W = 13;
  localparam logic [ADDR_W-1:0] START_ADDR = '0;

  logic              clk;
  logic              rst;
  logic              start;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              exec_valid;
  logic              pc_src;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int unsigned m_pc;
  logic [2:0]  m_op;
  logic [12:0] m_operand;
  bit          m_halted;

  fetch_sequencer #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .opcode     (opcode),
    .operand    (operand),
    .exec_valid (exec_valid),
    .pc_src     (pc_src),
    .pc         (pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // At a negedge in IDLE/HALT: pulse start, expect a fetch at START_ADDR
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = 32'(START_ADDR);
    m_halted = 1'b0;
    check_val("start_halted", {31'd0, halted}, 32'd0);
    check_val("start_req", {31'd0, imem_req}, 32'd1);
    check_val("start_addr", {19'd0, imem_addr}, m_pc);
  endtask

  // At a negedge in FETCH: wait, ack with instr, drive psrc in EXEC, check result
  task automatic run_instr(input logic [15:0] instr, input int wait_cyc, input bit psrc);
    logic [2:0]  op;
    logic [12:0] opd;
    op  = instr[15:13];
    opd = instr[12:0];
    for (int i = 0; i < wait_cyc; i++) begin
      start = 1'($urandom);
      check_val("wait_req", {31'd0, imem_req}, 32'd1);
      check_val("wait_addr", {19'd0, imem_addr}, m_pc);
      check_val("wait_exec", {31'd0, exec_valid}, 32'd0);
      check_val("wait_opcode_hold", {29'd0, opcode}, {29'd0, m_op});
      @(negedge clk);
    end
    check_val("fetch_req", {31'd0, imem_req}, 32'd1);
    check_val("fetch_addr", {19'd0, imem_addr}, m_pc);
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    m_op = op;
    m_operand = opd;
    check_val("exec_valid", {31'd0, exec_valid}, 32'd1);
    check_val("exec_opcode", {29'd0, opcode}, {29'd0, m_op});
    check_val("exec_operand", {19'd0, operand}, {19'd0, m_operand});
    check_val("exec_req", {31'd0, imem_req}, 32'd0);
    pc_src = psrc;
    start  = 1'($urandom);
    @(negedge clk);
    pc_src = 1'($urandom);
    if (op == 3'b111) begin
      m_pc = (m_pc + 1) % 8192;
      m_halted = 1'b1;
    end else if (psrc) begin
      m_pc = 32'(opd);
    end else begin
      m_pc = (m_pc + 1) % 8192;
    end
    check_val("post_pc", {19'd0, pc}, m_pc);
    check_val("post_exec", {31'd0, exec_valid}, 32'd0);
    check_val("post_halted", {31'd0, halted}, {31'd0, m_halted});
    check_val("post_req", {31'd0, imem_req}, {31'd0, !m_halted});
    if (!m_halted) check_val("post_addr", {19'd0, imem_addr}, m_pc);
    check_val("post_opcode_hold", {29'd0, opcode}, {29'd0, m_op});
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] instr;
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0; pc_src = 1'b0;
    m_pc = 0; m_op = '0; m_operand = '0; m_halted = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_req", {31'd0, imem_req}, 32'd0);
    check_val("rst_pc", {19'd0, pc}, 32'd0);
    check_val("rst_opcode", {29'd0, opcode}, 32'd0);
    check_val("rst_operand", {19'd0, operand}, 32'd0);
    check_val("rst_exec", {31'd0, exec_valid}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_req", {31'd0, imem_req}, 32'd0);

    // basic stream, delayed ack, HLT at pc=3 and restart
    do_start();
    run_instr(16'h4005, 0, 1'b0);
    run_instr(16'h2006, 0, 1'b0);
    run_instr(16'hC123, 3, 1'b0);
    run_instr(16'hE000, 0, 1'b1);
    check_val("hlt_pc4", {19'd0, pc}, 32'd4);
    @(negedge clk);
    check_val("halt_stay", {31'd0, halted}, 32'd1);
    check_val("halt_noreq", {31'd0, imem_req}, 32'd0);
    do_start();

    // jumps and PC wrap
    run_instr(16'h800A, 0, 1'b1);
    check_val("jmp_addr", {19'd0, imem_addr}, 32'd10);
    run_instr(16'hA00F, 0, 1'b0);
    check_val("jez_nt_addr", {19'd0, imem_addr}, 32'd11);
    run_instr(16'h9FFF, 1, 1'b1);
    run_instr(16'h4001, 0, 1'b0);
    check_val("wrap_addr", {19'd0, imem_addr}, 32'd0);

    // reset mid-fetch: req drops at once, late ack is ignored
    check_val("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("midrst_req", {31'd0, imem_req}, 32'd0);
    check_val("midrst_pc", {19'd0, pc}, {19'd0, START_ADDR});
    @(negedge clk);
    rst = 1'b0;
    m_op = '0; m_operand = '0; m_pc = 0;
    imem_ack = 1'b1; imem_rdata = 16'h600C;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check_val("late_ack_exec", {31'd0, exec_valid}, 32'd0);
    check_val("late_ack_req", {31'd0, imem_req}, 32'd0);
    check_val("late_ack_opcode", {29'd0, opcode}, 32'd0);

    // randomized instruction streams
    do_start();
    for (int n = 0; n < 400; n++) begin
      instr = 16'($urandom);
      if ($urandom_range(0, 9) == 0) instr[12:0] = 13'h1FFF;
      run_instr(instr, int'($urandom_range(0, 3)), 1'($urandom));
      if (m_halted) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check_val("rnd_halt", {31'd0, halted}, 32'd1);
        do_start();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
